data_memory_ctrl: RTL and testbench

- Parametrised, word-organised data memory for the single-cycle core's load/store path.
- Supports RV32I byte, halfword and word accesses with sign/zero extension and byte-enable writes.
- Uses a req/ready handshake with a configurable wait-state count, so slower memory timing can be modelled.
- Detects misaligned, out-of-range and illegal-funct3 accesses and reports them to the core.

---
 rtl/dmem_pkg.sv | 38 +++
 rtl/dmem_lane_align.sv | 56 +++++
 rtl/data_memory_ctrl.sv | 171 +++++++++++++++++
 tb/tb_data_memory_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data memory controller: funct3 codes,
// FSM states and the fault priority order.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Enumeration order mirrors reporting priority: illegal beats misalign beats range.
  typedef enum logic [1:0] {
    FLT_NONE     = 2'd0,
    FLT_ILLEGAL  = 2'd1,
    FLT_MISALIGN = 2'd2,
    FLT_RANGE    = 2'd3
  } dmem_fault_t;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic dmem_fault_t fault_pick(input logic illegal, input logic misalign,
                                             input logic out_range);
    if (illegal)   return FLT_ILLEGAL;
    if (misalign)  return FLT_MISALIGN;
    if (out_range) return FLT_RANGE;
    return FLT_NONE;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering between the core's load/store view and the
// 32-bit memory word: byte enables and replicated store data, plus
// lane selection with sign/zero extension for loads.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  byte_en,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // Store path: enable only the addressed lanes, replicate data so every lane sees it.
  always_comb begin
    byte_en    = 4'b0000;
    wdata_lane = wdata;
    case (funct3)
      F3_B: begin
        byte_en    = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
      end
      F3_H: begin
        byte_en    = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
      end
      F3_W: byte_en = 4'b1111;
      default: ;
    endcase
  end

  // Load path: pick the little-endian lane, then extend as funct3 asks.
  always_comb begin
    case (addr_lo)
      2'd0:    sel_byte = word[7:0];
      2'd1:    sel_byte = word[15:8];
      2'd2:    sel_byte = word[23:16];
      default: sel_byte = word[31:24];
    endcase
    sel_half = addr_lo[1] ? word[31:16] : word[15:0];
    case (funct3)
      F3_B:    rdata_ext = {{24{sel_byte[7]}}, sel_byte};
      F3_BU:   rdata_ext = {24'd0, sel_byte};
      F3_H:    rdata_ext = {{16{sel_half[15]}}, sel_half};
      F3_HU:   rdata_ext = {16'd0, sel_half};
      F3_W:    rdata_ext = word;
      default: rdata_ext = 32'd0;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Word-organised data memory for the core's load/store path with a
// req/ready handshake, programmable wait states and fault reporting.
//
//   state | meaning
//   IDLE  | waiting for req; request fields taken straight from the inputs
//   WAIT  | request latched, counting down extra wait states
//   RESP  | ready strobe with rdata / fault flags, one cycle only
module data_memory_ctrl
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        we,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        busy,
  output logic        fault_misalign,
  output logic        fault_range,
  output logic        fault_illegal
);

  localparam int         AW      = $clog2(DEPTH_WORDS);
  localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  dmem_state_t state;
  logic [3:0]  wait_cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [2:0]  f3_q;
  logic        we_q;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [2:0]  cur_f3;
  logic        cur_we;
  logic [31:0] offset;
  logic [31:0] word_idx;
  logic        illegal;
  logic        misalign;
  logic        out_range;
  dmem_fault_t fault;
  logic        enter_resp;
  logic [31:0] mem_word;
  logic [3:0]  byte_en;
  logic [31:0] wdata_lane;
  logic [31:0] load_ext;

  // In IDLE the request is live on the inputs (WAIT_STATES=0 commits on the
  // accept edge); afterwards only the latched copy is trusted.
  always_comb begin
    if (state == IDLE) begin
      cur_addr  = addr;
      cur_wdata = wdata;
      cur_f3    = funct3;
      cur_we    = we;
    end else begin
      cur_addr  = addr_q;
      cur_wdata = wdata_q;
      cur_f3    = f3_q;
      cur_we    = we_q;
    end
  end

  // Fault evaluation; the index is a plain 32-bit subtraction so nothing wraps into range.
  always_comb begin
    offset     = cur_addr - BASE_ADDR;
    word_idx   = offset >> 2;
    illegal    = !f3_legal(cur_we, cur_f3);
    misalign   = ((cur_f3[1:0] == 2'b01) && cur_addr[0]) ||
                 ((cur_f3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
    out_range  = (cur_addr < BASE_ADDR) || (word_idx >= 32'(DEPTH_WORDS));
    fault      = fault_pick(illegal, misalign, out_range);
    mem_word   = mem[word_idx[AW-1:0]];
    enter_resp = ((state == IDLE) && req && (WAIT_STATES == 0)) ||
                 ((state == WAIT) && (wait_cnt == 4'd0));
  end

  dmem_lane_align u_lane_align (
    .funct3     (cur_f3),
    .addr_lo    (cur_addr[1:0]),
    .wdata      (cur_wdata),
    .word       (mem_word),
    .byte_en    (byte_en),
    .wdata_lane (wdata_lane),
    .rdata_ext  (load_ext)
  );

  // Store commit on the edge entering RESP; contents deliberately survive reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (enter_resp && cur_we && (fault == FLT_NONE)) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) mem[word_idx[AW-1:0]][8*i +: 8] <= wdata_lane[8*i +: 8];
      end
    end
  end

  // Handshake FSM with registered response outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      wait_cnt       <= 4'd0;
      addr_q         <= 32'd0;
      wdata_q        <= 32'd0;
      f3_q           <= 3'd0;
      we_q           <= 1'b0;
      rdata          <= 32'd0;
      ready          <= 1'b0;
      busy           <= 1'b0;
      fault_misalign <= 1'b0;
      fault_range    <= 1'b0;
      fault_illegal  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            f3_q    <= funct3;
            we_q    <= we;
            busy    <= 1'b1;
            if (WAIT_STATES > 0) begin
              state    <= WAIT;
              wait_cnt <= WS_LOAD;
            end else begin
              state          <= RESP;
              ready          <= 1'b1;
              rdata          <= (!cur_we && (fault == FLT_NONE)) ? load_ext : 32'd0;
              fault_illegal  <= (fault == FLT_ILLEGAL);
              fault_misalign <= (fault == FLT_MISALIGN);
              fault_range    <= (fault == FLT_RANGE);
            end
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            state          <= RESP;
            ready          <= 1'b1;
            rdata          <= (!cur_we && (fault == FLT_NONE)) ? load_ext : 32'd0;
            fault_illegal  <= (fault == FLT_ILLEGAL);
            fault_misalign <= (fault == FLT_MISALIGN);
            fault_range    <= (fault == FLT_RANGE);
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          state          <= IDLE;
          ready          <= 1'b0;
          busy           <= 1'b0;
          rdata          <= 32'd0;
          fault_illegal  <= 1'b0;
          fault_misalign <= 1'b0;
          fault_range    <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (no wait states at base 0,
// three wait states at base 0x400) checked against a byte-level model.
module tb_data_memory_ctrl;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0400;

  logic        clk;
  logic        rst_a   [2];
  logic        req_a   [2];
  logic        we_a    [2];
  logic [2:0]  f3_a    [2];
  logic [31:0] addr_a  [2];
  logic [31:0] wdata_a [2];
  logic [31:0] rdata_a [2];
  logic        ready_a [2];
  logic        busy_a  [2];
  logic        fm_a    [2];
  logic        fr_a    [2];
  logic        fi_a    [2];

  logic [31:0] mdl [2][64];
  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        w;
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic [2:0]  flt;
  } dir_t;
  dir_t dir_tbl[$];

  data_memory_ctrl #(.DEPTH_WORDS(64), .BASE_ADDR(BASE0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_a[0]), .req(req_a[0]), .we(we_a[0]), .funct3(f3_a[0]),
    .addr(addr_a[0]), .wdata(wdata_a[0]), .rdata(rdata_a[0]), .ready(ready_a[0]),
    .busy(busy_a[0]), .fault_misalign(fm_a[0]), .fault_range(fr_a[0]), .fault_illegal(fi_a[0])
  );

  data_memory_ctrl #(.DEPTH_WORDS(64), .BASE_ADDR(BASE1), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst_n(rst_a[1]), .req(req_a[1]), .we(we_a[1]), .funct3(f3_a[1]),
    .addr(addr_a[1]), .wdata(wdata_a[1]), .rdata(rdata_a[1]), .ready(ready_a[1]),
    .busy(busy_a[1]), .fault_misalign(fm_a[1]), .fault_range(fr_a[1]), .fault_illegal(fi_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? BASE0 : BASE1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  // Reference: access semantics from the byte-level rules; flags are {illegal, misalign, range}.
  task automatic model(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] erd, output logic [2:0] eflt);
    logic [31:0] base;
    int size, lane, idx;
    bit legal, mis, rng;
    longint unsigned lmask, v, sign;
    logic [31:0] mask, word;
    base = base_of(d);
    erd  = 32'd0;
    eflt = 3'b000;
    if (w) legal = (f3 == 0) || (f3 == 1) || (f3 == 2);
    else   legal = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
    size = 1 << (f3 % 4);
    mis  = (a % size) != 0;
    rng  = (a < base) || (((a - base) / 4) >= 64);
    if (!legal)   eflt = 3'b100;
    else if (mis) eflt = 3'b010;
    else if (rng) eflt = 3'b001;
    else begin
      idx   = int'((a - base) / 4);
      lane  = int'(a % 4);
      word  = mdl[d][idx];
      lmask = (64'd1 << (8 * size)) - 1;
      if (w) begin
        mask        = 32'(lmask << (8 * lane));
        mdl[d][idx] = (word & ~mask) | (32'(wd << (8 * lane)) & mask);
      end else begin
        v    = (longint'(word) >> (8 * lane)) & lmask;
        sign = (v >> (8 * size - 1)) & 1;
        if (f3 < 4 && size < 4 && sign == 1) v = v | (~lmask);
        erd = 32'(v);
      end
    end
  endtask

  // One request with req dropped and inputs scrambled right after the accept edge.
  task automatic access(input int d, input logic w, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd, output logic [2:0] flt,
                        output int lat, output logic clean, output logic after_ok);
    @(negedge clk);
    req_a[d] = 1'b1; we_a[d] = w; f3_a[d] = f3; addr_a[d] = a; wdata_a[d] = wd;
    @(posedge clk);
    #1;
    req_a[d] = 1'b0; we_a[d] = 1'($urandom); f3_a[d] = 3'($urandom);
    addr_a[d] = $urandom; wdata_a[d] = $urandom;
    lat = -1; clean = 1'b1; rd = 32'd0; flt = 3'b000;
    for (int k = 1; k <= 24; k++) begin
      @(negedge clk);
      if (!busy_a[d]) clean = 1'b0;
      if (ready_a[d]) begin
        lat = k;
        rd  = rdata_a[d];
        flt = {fi_a[d], fm_a[d], fr_a[d]};
        break;
      end
      if (fi_a[d] || fm_a[d] || fr_a[d]) clean = 1'b0;
    end
    @(negedge clk);
    after_ok = !ready_a[d] && !busy_a[d] && !fi_a[d] && !fm_a[d] && !fr_a[d];
  endtask

  task automatic test_reset();
    for (int d = 0; d < 2; d++) begin
      total++;
      if ({rdata_a[d], ready_a[d], busy_a[d], fi_a[d], fm_a[d], fr_a[d]} !== 37'd0) begin
        bad++;
        $display("FAIL reset_outputs dut%0d: got rdata=%h ready=%b busy=%b fi=%b fm=%b fr=%b want all zero",
                 d, rdata_a[d], ready_a[d], busy_a[d], fi_a[d], fm_a[d], fr_a[d]);
      end
    end
  endtask

  task automatic test_prefill();
    logic [31:0] rd, erd, v;
    logic [2:0] flt, eflt;
    int lat;
    logic clean, after_ok;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        v = $urandom;
        model(d, 1'b1, 3'b010, base_of(d) + 32'(4 * i), v, erd, eflt);
        access(d, 1'b1, 3'b010, base_of(d) + 32'(4 * i), v, rd, flt, lat, clean, after_ok);
        total++;
        if (flt !== eflt || lat != ws_of(d) + 1) begin
          bad++;
          $display("FAIL prefill dut%0d word %0d: got flags=%b lat=%0d want flags=%b lat=%0d",
                   d, i, flt, lat, eflt, ws_of(d) + 1);
        end
      end
    end
  endtask

  task automatic add(input logic w, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] rd, input logic [2:0] flt);
    dir_t e;
    e.w = w; e.f3 = f3; e.a = a; e.wd = wd; e.rd = rd; e.flt = flt;
    dir_tbl.push_back(e);
  endtask

  task automatic test_directed();
    logic [31:0] rd, erd;
    logic [2:0] flt, eflt;
    int lat;
    logic clean, after_ok;
    add(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        3'b000);
    add(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 3'b000);
    add(1, 3'b000, 32'h11,  32'h12345680, 32'h0,        3'b000);
    add(0, 3'b000, 32'h11,  32'h0,        32'hFFFFFF80, 3'b000);
    add(0, 3'b100, 32'h11,  32'h0,        32'h00000080, 3'b000);
    add(0, 3'b010, 32'h10,  32'h0,        32'hDEAD80EF, 3'b000);
    add(1, 3'b001, 32'h12,  32'hABCD1234, 32'h0,        3'b000);
    add(0, 3'b101, 32'h12,  32'h0,        32'h00001234, 3'b000);
    add(0, 3'b010, 32'h10,  32'h0,        32'h123480EF, 3'b000);
    add(1, 3'b001, 32'h10,  32'h55558001, 32'h0,        3'b000);
    add(0, 3'b001, 32'h10,  32'h0,        32'hFFFF8001, 3'b000);
    add(0, 3'b010, 32'h10,  32'h0,        32'h12348001, 3'b000);
    add(0, 3'b000, 32'h13,  32'h0,        32'h00000012, 3'b000);
    add(1, 3'b010, 32'h0,   32'h0BADF00D, 32'h0,        3'b000);
    add(1, 3'b010, 32'hFC,  32'h600DCAFE, 32'h0,        3'b000);
    add(0, 3'b010, 32'h13,  32'h0,        32'h0,        3'b010);
    add(1, 3'b010, 32'h100, 32'h55555555, 32'h0,        3'b001);
    add(0, 3'b010, 32'h0,   32'h0,        32'h0BADF00D, 3'b000);
    add(0, 3'b010, 32'hFC,  32'h0,        32'h600DCAFE, 3'b000);
    add(0, 3'b001, 32'hFE,  32'h0,        32'h0000600D, 3'b000);
    add(0, 3'b011, 32'h10,  32'h0,        32'h0,        3'b100);
    add(1, 3'b011, 32'h101, 32'hFFFFFFFF, 32'h0,        3'b100);
    add(0, 3'b001, 32'h101, 32'h0,        32'h0,        3'b010);
    add(1, 3'b100, 32'h10,  32'hFFFFFFFF, 32'h0,        3'b100);
    add(0, 3'b010, 32'h10,  32'h0,        32'h12348001, 3'b000);
    add(0, 3'b010, 32'hFFFFFFFC, 32'h0,   32'h0,        3'b001);
    add(0, 3'b100, 32'h100, 32'h0,        32'h0,        3'b001);
    foreach (dir_tbl[i]) begin
      model(0, dir_tbl[i].w, dir_tbl[i].f3, dir_tbl[i].a, dir_tbl[i].wd, erd, eflt);
      access(0, dir_tbl[i].w, dir_tbl[i].f3, dir_tbl[i].a, dir_tbl[i].wd, rd, flt, lat, clean, after_ok);
      total++;
      if (lat != 1) begin
        bad++;
        $display("FAIL dir_latency row %0d: got %0d want 1", i, lat);
      end
      total++;
      if (clean !== 1'b1 || after_ok !== 1'b1) begin
        bad++;
        $display("FAIL dir_handshake row %0d: got busy_during=%b idle_after=%b want 1 1", i, clean, after_ok);
      end
      total++;
      if (flt !== dir_tbl[i].flt) begin
        bad++;
        $display("FAIL dir_flags row %0d: got %b want %b", i, flt, dir_tbl[i].flt);
      end
      if (!dir_tbl[i].w) begin
        total++;
        if (rd !== dir_tbl[i].rd) begin
          bad++;
          $display("FAIL dir_rdata row %0d: got %h want %h", i, rd, dir_tbl[i].rd);
        end
      end
    end
  endtask

  // req held high across two accesses: ready at the 4th and 9th sampled cycles.
  task automatic test_back_to_back();
    logic [31:0] exp;
    logic exp_busy, exp_ready;
    exp = mdl[1][8];
    @(negedge clk);
    req_a[1] = 1'b1; we_a[1] = 1'b0; f3_a[1] = 3'b010; addr_a[1] = BASE1 + 32'h20; wdata_a[1] = 32'h0;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      exp_ready = (k == 4) || (k == 9);
      exp_busy  = (k >= 1 && k <= 4) || (k >= 6 && k <= 9);
      total++;
      if (ready_a[1] !== exp_ready || busy_a[1] !== exp_busy) begin
        bad++;
        $display("FAIL b2b_timing cycle %0d: got ready=%b busy=%b want ready=%b busy=%b",
                 k, ready_a[1], busy_a[1], exp_ready, exp_busy);
      end
      if (exp_ready) begin
        total++;
        if (rdata_a[1] !== exp) begin
          bad++;
          $display("FAIL b2b_rdata cycle %0d: got %h want %h", k, rdata_a[1], exp);
        end
      end
      if (k == 6) req_a[1] = 1'b0;
    end
  endtask

  // Reset pulsed in WAIT must clear outputs at once and drop the pending store.
  task automatic test_reset_mid();
    logic [31:0] prior, rd;
    logic [2:0] flt;
    int lat;
    logic clean, after_ok;
    prior = mdl[1][8];
    @(negedge clk);
    req_a[1] = 1'b1; we_a[1] = 1'b1; f3_a[1] = 3'b010; addr_a[1] = BASE1 + 32'h20; wdata_a[1] = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    req_a[1] = 1'b0;
    @(negedge clk);
    total++;
    if (busy_a[1] !== 1'b1) begin
      bad++;
      $display("FAIL midrst_busy_before: got %b want 1", busy_a[1]);
    end
    @(negedge clk);
    rst_a[1] = 1'b0;
    #1;
    total++;
    if ({rdata_a[1], ready_a[1], busy_a[1], fi_a[1], fm_a[1], fr_a[1]} !== 37'd0) begin
      bad++;
      $display("FAIL midrst_outputs: got rdata=%h ready=%b busy=%b flags=%b%b%b want all zero",
               rdata_a[1], ready_a[1], busy_a[1], fi_a[1], fm_a[1], fr_a[1]);
    end
    @(negedge clk);
    rst_a[1] = 1'b1;
    access(1, 1'b0, 3'b010, BASE1 + 32'h20, 32'h0, rd, flt, lat, clean, after_ok);
    total++;
    if (rd !== prior || flt !== 3'b000 || lat != 4) begin
      bad++;
      $display("FAIL midrst_dropped_store: got rdata=%h flags=%b lat=%0d want rdata=%h flags=000 lat=4",
               rd, flt, lat, prior);
    end
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, a, wd;
    logic [2:0] flt, eflt, f3;
    logic w;
    int lat, pick;
    logic clean, after_ok;
    logic [2:0] legal_f3 [5];
    legal_f3[0] = 3'b000; legal_f3[1] = 3'b001; legal_f3[2] = 3'b010;
    legal_f3[3] = 3'b100; legal_f3[4] = 3'b101;
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 150; n++) begin
        w    = 1'($urandom_range(0, 1));
        f3   = ($urandom_range(0, 7) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
        pick = $urandom_range(0, 15);
        if (pick < 13)       a = base_of(d) + 32'($urandom_range(0, 255));
        else if (pick == 13) a = base_of(d) + 32'd256 + 32'($urandom_range(0, 7));
        else if (pick == 14) a = base_of(d) - 32'd1 - 32'($urandom_range(0, 3));
        else                 a = $urandom;
        wd = $urandom;
        model(d, w, f3, a, wd, erd, eflt);
        access(d, w, f3, a, wd, rd, flt, lat, clean, after_ok);
        total++;
        if (lat != ws_of(d) + 1 || clean !== 1'b1 || after_ok !== 1'b1) begin
          bad++;
          $display("FAIL rand_handshake dut%0d #%0d: got lat=%0d busy_during=%b idle_after=%b want lat=%0d 1 1",
                   d, n, lat, clean, after_ok, ws_of(d) + 1);
        end
        total++;
        if (flt !== eflt) begin
          bad++;
          $display("FAIL rand_flags dut%0d #%0d we=%b f3=%b addr=%h: got %b want %b", d, n, w, f3, a, flt, eflt);
        end
        if (!w) begin
          total++;
          if (rd !== erd) begin
            bad++;
            $display("FAIL rand_rdata dut%0d #%0d f3=%b addr=%h: got %h want %h", d, n, f3, a, rd, erd);
          end
        end
      end
    end
  endtask

  task automatic test_sweep();
    logic [31:0] rd;
    logic [2:0] flt;
    int lat;
    logic clean, after_ok;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 64; i++) begin
        access(d, 1'b0, 3'b010, base_of(d) + 32'(4 * i), 32'h0, rd, flt, lat, clean, after_ok);
        total++;
        if (rd !== mdl[d][i] || flt !== 3'b000) begin
          bad++;
          $display("FAIL sweep dut%0d word %0d: got %h flags=%b want %h flags=000", d, i, rd, flt, mdl[d][i]);
        end
      end
    end
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst_a[d] = 1'b0; req_a[d] = 1'b0; we_a[d] = 1'b0; f3_a[d] = 3'b000;
      addr_a[d] = 32'h0; wdata_a[d] = 32'h0;
    end
    repeat (3) @(negedge clk);
    test_reset();
    rst_a[0] = 1'b1;
    rst_a[1] = 1'b1;
    @(negedge clk);
    test_reset();
    test_prefill();
    test_directed();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
